bt_cmd_rx: RTL and testbench
============================

# bt_cmd_rx

Bluetooth command receiver for the car controller: deserialises the 8N1 UART stream from the Bluetooth module, parses fixed 5-byte command packets, and drives the registered `DRT[3:0]` and `SPD[15:0]` words consumed by the main controller's direction shifter and PWM stages. It sits directly upstream of the main controller and runs on the same 50 MHz clock. A link watchdog forces all speeds to zero when valid packets stop arriving.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency.
- `BAUD`, 9600, UART bit rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (5208).
- `HEADER`, 8'hA5, packet start byte.
- `GAP_CYC`, 2*10*CLKS_PER_BIT, inter-byte timeout inside a packet.
- `WDT_CYC`, 25_000_000, link watchdog period (0.5 s).
- `clk50M`  in  1  system clock.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `rx`  in  1  UART line from the Bluetooth module; idle high, asynchronous.
- `DRT`  out  4  direction bits, registered.
- `SPD`  out  16  four 4-bit wheel speeds, registered; `[15:12]` is wheel 3.
- `cmd_valid`  out  1  one-cycle pulse when a packet is accepted.
- `cmd_err`  out  1  one-cycle pulse on checksum or framing error.
- `link_lost`  out  1  high while no valid packet has arrived within `WDT_CYC`.

## Operation
- Reset values: `DRT=0`, `SPD=0`, `cmd_valid=0`, `cmd_err=0`, `link_lost=1`. Parser in IDLE; UART in IDLE.
- `rx` passes through a 2-flop synchroniser (reset value 1).
- UART RX FSM: IDLE -> START on a synchronised falling edge; the bit is re-sampled at `CLKS_PER_BIT/2`. If it reads high, return to IDLE (glitch). Otherwise go to DATA, sampling 8 bits LSB first, each `CLKS_PER_BIT` apart at mid-bit. Then STOP: a mid-bit sample of 1 pulses the internal `byte_valid` with `byte_data`; a sample of 0 pulses `cmd_err` and drops the byte. Return to IDLE in either case.
- Packet format: `HEADER`, `D`, `SH`, `SL`, `CS`.
  - `DRT` is taken from `D[3:0]`; `D[7:4]` is ignored.
  - `SPD = {SH, SL}`.
  - `CS = D ^ SH ^ SL`.
- Parser FSM: IDLE -> GET_D -> GET_SH -> GET_SL -> GET_CS -> IDLE.
  - Each state advances on `byte_valid`.
  - In IDLE, any byte other than `HEADER` is discarded silently.
  - In the other states, a byte equal to `HEADER` is treated as data; there is no mid-packet resync.
- Acceptance (at GET_CS):
  - Match: load `DRT`/`SPD`, pulse `cmd_valid`, clear `link_lost`, restart the watchdog.
  - Mismatch: pulse `cmd_err`; outputs are unchanged.
- Gap counter: runs in every non-IDLE parser state and clears on each `byte_valid`. Reaching `GAP_CYC` returns the parser to IDLE silently, with no `cmd_err`.
- Watchdog: counts every cycle and clears on packet acceptance. Reaching `WDT_CYC` forces `SPD=0` and sets `link_lost=1`; `DRT` is held. The counter saturates, so the event fires once.
- Simultaneous acceptance and watchdog expiry in the same cycle: acceptance wins.
- A framing error mid-packet drops that byte only. The parser stays in its state and the gap timer still runs.

## Timing
- `byte_valid` is asserted in the cycle after the mid-stop-bit sample.
- `DRT`/`SPD`/`cmd_valid` update in the cycle after the `byte_valid` of `CS`: 1 cycle parser latency.
- End-to-end latency from the falling start edge of `CS` to the output update: 2 sync + 9.5 bit times + 2 cycles.
- Back-to-back bytes with zero idle time between the stop bit and the next start bit must be received.
- `cmd_valid` and `cmd_err` are single-cycle and never asserted together.
  - Exception: a framing error on the byte following a completed packet is a later cycle, so no overlap can occur.
- Reset asserted mid-byte or mid-packet returns all FSMs, counters and outputs to their reset values asynchronously. The partial packet is lost.

## Structure
- Shared package `bt_pkg`: `HEADER` default, parser state enum (`P_IDLE`, `P_D`, `P_SH`, `P_SL`, `P_CS`), UART state enum, packet length constant.
- One sub-module, `uart_rx_8n1` (params `CLKS_PER_BIT`). It contains the synchroniser, UART FSM and bit counters, and outputs `byte_valid`, `byte_data`, `frame_err`.
- Top level contains the parser FSM, checksum accumulator, gap counter, watchdog and output registers.

## Test plan
- Valid packet A5 05 3C 96 AF at 9600 baud -> `DRT=4'h5`, `SPD=16'h3C96`, one `cmd_valid` pulse, `link_lost` 1->0.
- Same packet with `CS=AE` -> `cmd_err` pulse; `DRT`/`SPD` hold their prior values; `cmd_valid` stays 0.
- Stop bit driven 0 on the `SH` byte, then the remaining bytes sent -> `cmd_err` pulse; the packet is not accepted, since the checksum byte lands in GET_SL.
- Send A5 05, idle > `GAP_CYC`, then A5 01 00 F0 F1 -> the first fragment is dropped; `DRT=1`, `SPD=16'h00F0` is accepted.
- `WDT_CYC=1000` override: accept A5 0A FF FF 0A, then idle 1000 cycles -> `SPD=0`, `DRT=4'hA`, `link_lost=1`.
- Assert `rst` low during the `SL` byte, release, then send a valid packet -> all outputs are at reset values during reset, and the new packet is accepted cleanly.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared constants and state encodings for the Bluetooth command receiver.
package bt_pkg;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam int         PKT_LEN    = 5;

  typedef enum logic [$clog2(PKT_LEN)-1:0] {P_IDLE, P_D, P_SH, P_SL, P_CS} pstate_e;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_e;
endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, one-cycle byte/framing pulses.
module uart_rx_8n1
  import bt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
)(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  ustate_e       st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;

  assign byte_data_o = sh_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      st_q         <= U_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (st_q)
        U_IDLE: if (rx_prev_q && !rx_sync_q) begin
          st_q  <= U_START;
          cnt_q <= '0;
        end
        // A start bit that is high again at mid-bit was a glitch.
        U_START: if (cnt_q == HALF) begin
          cnt_q <= '0;
          bit_q <= '0;
          st_q  <= rx_sync_q ? U_IDLE : U_DATA;
        end else cnt_q <= cnt_q + CW'(1);
        U_DATA: if (cnt_q == LAST) begin
          cnt_q <= '0;
          sh_q  <= {rx_sync_q, sh_q[7:1]};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) st_q <= U_STOP;
        end else cnt_q <= cnt_q + CW'(1);
        U_STOP: if (cnt_q == LAST) begin
          cnt_q        <= '0;
          st_q         <= U_IDLE;
          byte_valid_o <= rx_sync_q;
          frame_err_o  <= !rx_sync_q;
        end else cnt_q <= cnt_q + CW'(1);
        default: st_q <= U_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/bt_cmd_rx.sv
// Bluetooth command receiver: parses A5/D/SH/SL/CS packets into DRT/SPD with
// checksum, inter-byte gap timeout and a link watchdog that zeroes speeds.
module bt_cmd_rx
  import bt_pkg::*;
#(
  parameter int         CLK_HZ  = 50_000_000,
  parameter int         BAUD    = 9600,
  parameter logic [7:0] HEADER  = HEADER_DEF,
  parameter int         GAP_CYC = 2*10*(CLK_HZ/BAUD),
  parameter int         WDT_CYC = 25_000_000
)(
  input  logic        clk50M,
  input  logic        rst,
  input  logic        rx,
  output logic [3:0]  DRT,
  output logic [15:0] SPD,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic        link_lost
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int WW = $clog2(WDT_CYC + 1);

  logic          byte_valid, frame_err;
  logic [7:0]    byte_data;
  pstate_e       ps_q;
  logic [3:0]    d_q;
  logic [7:0]    sh_q, sl_q, cs_q;
  logic [GW-1:0] gap_q;
  logic [WW-1:0] wdt_q;
  logic          pkt_done, accept, wdt_fire;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (clk50M),
    .rst_ni       (rst),
    .rx_i         (rx),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  assign pkt_done = byte_valid && (ps_q == P_CS);
  assign accept   = pkt_done && (cs_q == byte_data);
  assign wdt_fire = (wdt_q == WW'(WDT_CYC - 1));

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      ps_q      <= P_IDLE;
      d_q       <= '0;
      sh_q      <= '0;
      sl_q      <= '0;
      cs_q      <= '0;
      gap_q     <= '0;
      wdt_q     <= '0;
      DRT       <= '0;
      SPD       <= '0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      link_lost <= 1'b1;
    end else begin
      cmd_valid <= accept;
      cmd_err   <= frame_err || (pkt_done && !accept);

      // Acceptance takes priority over a coincident watchdog expiry.
      if (accept) begin
        wdt_q     <= '0;
        DRT       <= d_q;
        SPD       <= {sh_q, sl_q};
        link_lost <= 1'b0;
      end else begin
        if (wdt_q != WW'(WDT_CYC)) wdt_q <= wdt_q + WW'(1);
        if (wdt_fire) begin
          SPD       <= '0;
          link_lost <= 1'b1;
        end
      end

      // Framing errors do not touch the parser; only the gap timer moves it.
      if (byte_valid) begin
        gap_q <= '0;
        case (ps_q)
          P_IDLE: if (byte_data == HEADER) ps_q <= P_D;
          P_D:  begin d_q <= byte_data[3:0]; cs_q <= byte_data;         ps_q <= P_SH; end
          P_SH: begin sh_q <= byte_data;     cs_q <= cs_q ^ byte_data;  ps_q <= P_SL; end
          P_SL: begin sl_q <= byte_data;     cs_q <= cs_q ^ byte_data;  ps_q <= P_CS; end
          default: ps_q <= P_IDLE;
        endcase
      end else if (ps_q != P_IDLE) begin
        if (gap_q == GW'(GAP_CYC)) begin
          ps_q  <= P_IDLE;
          gap_q <= '0;
        end else gap_q <= gap_q + GW'(1);
      end
    end
  end
endmodule

// File: tb/tb_bt_cmd_rx.sv
// Bench for bt_cmd_rx: directed packets plus random traffic against a
// byte-level packet model with time-based gap and watchdog rules.
module tb_bt_cmd_rx;
  localparam int CPB = 16;
  localparam int GAP = 30*CPB;
  localparam int WDT = 1000;
  localparam int MRG = 3*CPB;

  logic        clk50M = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic [3:0]  DRT;
  logic [15:0] SPD;
  logic        cmd_valid, cmd_err, link_lost;

  bt_cmd_rx #(
    .CLK_HZ(160), .BAUD(10), .HEADER(8'hA5), .GAP_CYC(GAP), .WDT_CYC(WDT)
  ) dut (
    .clk50M(clk50M), .rst(rst), .rx(rx), .DRT(DRT), .SPD(SPD),
    .cmd_valid(cmd_valid), .cmd_err(cmd_err), .link_lost(link_lost)
  );

  always #5 clk50M = ~clk50M;

  int cyc = 0;
  int n_vld = 0, n_err = 0, n_both = 0;
  always @(posedge clk50M) cyc++;
  always @(negedge clk50M) begin
    if (cmd_valid) n_vld++;
    if (cmd_err) n_err++;
    if (cmd_valid && cmd_err) n_both++;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Packet model: position in packet, stored fields, last accepted values.
  int         ps = 0;
  logic [7:0] md, msh, msl;
  logic [3:0] m_drt = '0;
  logic [15:0] m_spd = '0;
  bit         have_acc = 0;
  int         last_acc = 0, last_good = 0;
  int         e_vld = 0, e_err = 0;

  task automatic model_byte(input logic [7:0] b, input int s, input bit good);
    if (!good) begin e_err++; return; end
    if (ps != 0 && (s - last_good) > GAP) ps = 0;
    last_good = s;
    case (ps)
      0: if (b == 8'hA5) ps = 1;
      1: begin md = b;  ps = 2; end
      2: begin msh = b; ps = 3; end
      3: begin msl = b; ps = 4; end
      default: begin
        if (b == (md ^ msh ^ msl)) begin
          e_vld++;
          m_drt = md[3:0];
          m_spd = {msh, msl};
          have_acc = 1;
          last_acc = s + 10*CPB;
        end else e_err++;
        ps = 0;
      end
    endcase
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk50M);
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit stop_ok);
    int s;
    s = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk50M);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk50M);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk50M);
    if (!stop_ok) idle(CPB);
    model_byte(b, s, stop_ok);
  endtask

  task automatic tx_pkt(input logic [7:0] h, d, sh, sl, cs);
    tx_byte(h, 1'b1); tx_byte(d, 1'b1); tx_byte(sh, 1'b1);
    tx_byte(sl, 1'b1); tx_byte(cs, 1'b1);
  endtask

  task automatic check_out(input string tag);
    int age;
    chk({tag, "_drt"}, 32'(DRT), 32'(m_drt));
    chk({tag, "_nvld"}, n_vld, e_vld);
    chk({tag, "_nerr"}, n_err, e_err);
    age = have_acc ? (cyc - last_acc) : WDT + 10*MRG;
    if (age > WDT + MRG) begin
      chk({tag, "_lost"}, 32'(link_lost), 32'd1);
      chk({tag, "_spd"}, 32'(SPD), 32'd0);
    end else if (age < WDT - MRG) begin
      chk({tag, "_lost"}, 32'(link_lost), 32'd0);
      chk({tag, "_spd"}, 32'(SPD), 32'(m_spd));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_drt"}, 32'(DRT), 32'd0);
    chk({tag, "_spd"}, 32'(SPD), 32'd0);
    chk({tag, "_vld"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_err"}, 32'(cmd_err), 32'd0);
    chk({tag, "_lost"}, 32'(link_lost), 32'd1);
  endtask

  initial begin
    logic [7:0] pk [5];
    int bad;
    repeat (3) @(negedge clk50M);
    check_reset_vals("rst0");
    rst = 1'b1;
    idle(4*CPB);

    tx_pkt(8'hA5, 8'h05, 8'h3C, 8'h96, 8'hAF);
    idle(CPB);
    check_out("pkt_ok");

    tx_pkt(8'hA5, 8'h05, 8'h3C, 8'h96, 8'hAE);
    idle(CPB);
    check_out("pkt_badcs");

    tx_byte(8'hA5, 1'b1); tx_byte(8'h05, 1'b1); tx_byte(8'h3C, 1'b0);
    tx_byte(8'h96, 1'b1); tx_byte(8'hAF, 1'b1);
    idle(CPB);
    check_out("pkt_frame");
    idle(40*CPB);

    tx_byte(8'hA5, 1'b1); tx_byte(8'h05, 1'b1);
    idle(40*CPB);
    tx_pkt(8'hA5, 8'h01, 8'h00, 8'hF0, 8'hF1);
    idle(CPB);
    check_out("pkt_gap");

    tx_pkt(8'hA5, 8'h0A, 8'hFF, 8'hFF, 8'h0A);
    idle(CPB);
    check_out("wdt_pre");
    idle(1100);
    check_out("wdt_post");

    tx_byte(8'hA5, 1'b1); tx_byte(8'h07, 1'b1); tx_byte(8'h12, 1'b1);
    rx = 1'b0;
    repeat (3*CPB) @(negedge clk50M);
    rst = 1'b0;
    repeat (2) @(negedge clk50M);
    check_reset_vals("rst_mid");
    ps = 0; m_drt = '0; m_spd = '0; have_acc = 0;
    rx = 1'b1;
    repeat (2*CPB) @(negedge clk50M);
    rst = 1'b1;
    idle(2*CPB);
    tx_pkt(8'hA5, 8'h03, 8'h12, 8'h34, 8'h03 ^ 8'h12 ^ 8'h34);
    idle(CPB);
    check_out("rst_after");

    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pk[0] = 8'($urandom);
        if (pk[0] == 8'hA5) pk[0] = 8'h5A;
        tx_byte(pk[0], 1'b1);
      end
      pk[0] = 8'hA5;
      pk[1] = 8'($urandom);
      pk[2] = 8'($urandom);
      pk[3] = 8'($urandom);
      pk[4] = pk[1] ^ pk[2] ^ pk[3];
      if ($urandom_range(0, 3) == 0) pk[4] = pk[4] ^ (8'h01 << $urandom_range(0, 7));
      bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : -1;
      for (int i = 0; i < 5; i++) begin
        tx_byte(pk[i], i != bad);
        idle($urandom_range(0, 2*CPB));
      end
      if ($urandom_range(0, 4) == 0) idle(40*CPB);
      idle(CPB);
      check_out("rnd");
    end

    chk("no_overlap", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
